// File: rtl/dcache_load_responder.sv
// Memory-side load responder: 128B line refills and single uncached Gets over a
// 32-bit TileLink-UL-style bus, writing refilled lines into the data/tag arrays.
module dcache_load_responder #(
  parameter int LINE_BEATS = 32
) (
  input  logic        core_clock_i,
  input  logic        core_reset_ni,
  input  logic        dc_req,
  input  logic [31:0] dc_addr,
  input  logic [1:0]  dc_op,
  input  logic        dc_uncached,
  output logic [31:0] dc_data,
  output logic        dc_cmp,
  output logic        a_valid,
  input  logic        a_ready,
  output logic [31:0] a_address,
  output logic [2:0]  a_size,
  input  logic        d_valid,
  output logic        d_ready,
  input  logic [31:0] d_data,
  input  logic        d_denied,
  output logic        bram_wr_en,
  output logic [9:0]  bram_wr_addr,
  output logic [63:0] bram_wr_data,
  output logic        tag_wr_en,
  output logic        tag_wr_way,
  output logic [23:0] tag_wr_line,
  output logic        bus_err_o
);

  localparam int BW = $clog2(LINE_BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic [31:0]     addr_r;
  logic [1:0]      op_r;
  logic            unc_r;
  logic            err_r, err_s;
  logic            hold_r;
  logic            victim_r;
  logic [BW-1:0]   beat_r;
  logic [31:0]     low_r;
  logic            accept_s;
  logic            beat_fire_s;

  // Right-justify a byte or halfword from a 32-bit bus word; upper bits zero.
  function automatic logic [31:0] align_load(input logic [31:0] raw,
                                             input logic [1:0]  op,
                                             input logic [1:0]  off);
    logic [31:0] sh;
    logic [31:0] res;
    sh  = 32'd0;
    res = raw;
    case (op)
      2'd0: begin
        sh  = raw >> {off, 3'b000};
        res = {24'd0, sh[7:0]};
      end
      2'd1: begin
        sh  = raw >> {off[1], 4'b0000};
        res = {16'd0, sh[15:0]};
      end
      default: res = raw;
    endcase
    return res;
  endfunction

  always_comb begin
    state_s     = state_r;
    err_s       = err_r;
    accept_s    = 1'b0;
    beat_fire_s = 1'b0;
    case (state_r)
      IDLE: begin
        err_s = 1'b0;
        // hold_r blocks re-accepting the request that just completed
        if (dc_req && !hold_r) begin
          accept_s = 1'b1;
          state_s  = REQ;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (a_valid && a_ready) begin
          state_s = RESP;
        end else begin
          state_s = REQ;
        end
      end
      RESP: begin
        if (d_valid) begin
          beat_fire_s = 1'b1;
          err_s       = err_r | d_denied;
          if (unc_r || (beat_r == LAST_BEAT)) begin
            state_s = DONE;
          end else begin
            state_s = RESP;
          end
        end else begin
          state_s = RESP;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  always_ff @(posedge core_clock_i or negedge core_reset_ni) begin
    if (!core_reset_ni) begin
      state_r      <= IDLE;
      err_r        <= 1'b0;
      hold_r       <= 1'b0;
      victim_r     <= 1'b0;
      beat_r       <= '0;
      low_r        <= 32'd0;
      addr_r       <= 32'd0;
      op_r         <= 2'd0;
      unc_r        <= 1'b0;
      dc_data      <= 32'd0;
      dc_cmp       <= 1'b0;
      a_valid      <= 1'b0;
      a_address    <= 32'd0;
      a_size       <= 3'd0;
      d_ready      <= 1'b0;
      bram_wr_en   <= 1'b0;
      bram_wr_addr <= 10'd0;
      bram_wr_data <= 64'd0;
      tag_wr_en    <= 1'b0;
      tag_wr_way   <= 1'b0;
      tag_wr_line  <= 24'd0;
      bus_err_o    <= 1'b0;
    end else begin
      state_r    <= state_s;
      err_r      <= err_s;
      hold_r     <= (state_r == DONE);
      a_valid    <= (state_s == REQ);
      d_ready    <= (state_s == RESP);
      dc_cmp     <= (state_s == DONE);
      bus_err_o  <= (state_s == DONE) && err_s;
      tag_wr_en  <= (state_s == DONE) && !unc_r && !err_s;
      bram_wr_en <= beat_fire_s && !unc_r && beat_r[0];
      if (accept_s) begin
        addr_r    <= dc_addr;
        op_r      <= dc_op;
        unc_r     <= dc_uncached;
        beat_r    <= '0;
        a_address <= dc_uncached ? dc_addr : {dc_addr[31:7], 7'd0};
        a_size    <= dc_uncached ? {1'b0, dc_op} : 3'd7;
      end
      // Even beats park in low_r; each odd beat completes one 64-bit word
      if (beat_fire_s && !unc_r) begin
        beat_r <= beat_r + BW'(1);
        if (!beat_r[0]) begin
          low_r <= d_data;
        end else begin
          bram_wr_addr <= {victim_r, addr_r[11:7], beat_r[BW-1:1]};
          bram_wr_data <= {d_data, low_r};
        end
      end
      if (beat_fire_s && unc_r) begin
        dc_data <= d_denied ? 32'd0 : align_load(d_data, op_r, addr_r[1:0]);
      end
      if ((state_s == DONE) && !unc_r) begin
        tag_wr_way  <= victim_r;
        tag_wr_line <= addr_r[30:7];
      end
      if ((state_r == DONE) && !unc_r) begin
        victim_r <= ~victim_r;
      end
    end
  end

endmodule

// File: tb/tb_dcache_load_responder.sv
// Directed scoreboard bench for dcache_load_responder: expected writes, tags and
// completions are queued as stimulus is driven and popped against a monitor.
module tb_dcache_load_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dc_req = 1'b0;
  logic [31:0] dc_addr = 32'd0;
  logic [1:0]  dc_op = 2'd0;
  logic        dc_uncached = 1'b0;
  logic [31:0] dc_data;
  logic        dc_cmp;
  logic        a_valid;
  logic        a_ready = 1'b0;
  logic [31:0] a_address;
  logic [2:0]  a_size;
  logic        d_valid = 1'b0;
  logic        d_ready;
  logic [31:0] d_data = 32'd0;
  logic        d_denied = 1'b0;
  logic        bram_wr_en;
  logic [9:0]  bram_wr_addr;
  logic [63:0] bram_wr_data;
  logic        tag_wr_en;
  logic        tag_wr_way;
  logic [23:0] tag_wr_line;
  logic        bus_err_o;

  dcache_load_responder #(.LINE_BEATS(32)) dut (
    .core_clock_i (clk),
    .core_reset_ni(rst_n),
    .dc_req       (dc_req),
    .dc_addr      (dc_addr),
    .dc_op        (dc_op),
    .dc_uncached  (dc_uncached),
    .dc_data      (dc_data),
    .dc_cmp       (dc_cmp),
    .a_valid      (a_valid),
    .a_ready      (a_ready),
    .a_address    (a_address),
    .a_size       (a_size),
    .d_valid      (d_valid),
    .d_ready      (d_ready),
    .d_data       (d_data),
    .d_denied     (d_denied),
    .bram_wr_en   (bram_wr_en),
    .bram_wr_addr (bram_wr_addr),
    .bram_wr_data (bram_wr_data),
    .tag_wr_en    (tag_wr_en),
    .tag_wr_way   (tag_wr_way),
    .tag_wr_line  (tag_wr_line),
    .bus_err_o    (bus_err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [73:0] obs_wr[$],  exp_wr[$];
  logic [24:0] obs_tag[$], exp_tag[$];
  logic [32:0] obs_cmp[$], exp_cmp[$];
  int          cmp_cyc = 0;
  int          stray_err = 0;

  always @(negedge clk) begin
    if (bram_wr_en) obs_wr.push_back({bram_wr_addr, bram_wr_data});
    if (tag_wr_en)  obs_tag.push_back({tag_wr_way, tag_wr_line});
    if (dc_cmp) begin
      obs_cmp.push_back({bus_err_o, dc_data});
      cmp_cyc = cyc;
    end
    if (bus_err_o && !dc_cmp) stray_err++;
  end

  int   checks = 0;
  int   errors = 0;
  logic victim_m = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] d, input logic [1:0] op,
                                             input logic [1:0] off);
    logic [31:0] r;
    case (op)
      2'd0:    r = {24'd0, d[8*off +: 8]};
      2'd1:    r = off[1] ? {16'd0, d[31:16]} : {16'd0, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  task automatic run_txn(input string nm, input logic [31:0] addr, input logic [1:0] op,
                         input logic unc, input logic [31:0] seed, input int deny,
                         input int rdy_delay, input bit gaps, input int exp_lat);
    int          nb;
    int          start;
    logic        err;
    logic [31:0] d, prev, exp_d;
    logic [4:0]  kk;
    logic [32:0] oc, ec;
    nb   = unc ? 1 : 32;
    err  = (deny >= 0) && (deny < nb);
    prev = 32'd0;
    @(posedge clk); #1;
    start       = cyc;
    dc_req      = 1'b1;
    dc_addr     = addr;
    dc_op       = op;
    dc_uncached = unc;
    a_ready     = (rdy_delay == 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_valid) break;
    end
    check({nm, ".a_valid"}, a_valid, 1'b1);
    check({nm, ".a_address"}, a_address, unc ? addr : {addr[31:7], 7'd0});
    check({nm, ".a_size"}, a_size, unc ? {1'b0, op} : 3'd7);
    if (rdy_delay > 0) begin
      d_valid = 1'b1;
      d_data  = 32'hBAD0_0000;
      repeat (rdy_delay) @(posedge clk);
      #1 a_ready = 1'b1;
    end
    @(posedge clk); #1;
    a_ready = 1'b0;
    d_valid = 1'b0;
    check({nm, ".a_valid_drop"}, a_valid, 1'b0);
    for (int k = 0; k < nb; k++) begin
      if (gaps && (k % 3 == 1)) begin
        d_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
      end
      kk       = 5'(k);
      d        = unc ? seed : seed + 32'(k);
      d_valid  = 1'b1;
      d_data   = d;
      d_denied = (k == deny);
      if (!unc && kk[0]) exp_wr.push_back({victim_m, addr[11:7], kk[4:1], d, prev});
      prev = d;
      @(posedge clk); #1;
    end
    d_valid  = 1'b0;
    d_denied = 1'b0;
    exp_d = (unc && !err) ? model_load(seed, op, addr[1:0]) : 32'd0;
    exp_cmp.push_back({err, exp_d});
    if (!unc && !err) exp_tag.push_back({victim_m, addr[30:7]});
    if (!unc) victim_m = ~victim_m;
    for (int i = 0; i < 40 && obs_cmp.size() == 0; i++) @(posedge clk);
    #1 dc_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check({nm, ".n_writes"}, obs_wr.size(), exp_wr.size());
    while (obs_wr.size() > 0 && exp_wr.size() > 0)
      check({nm, ".write"}, obs_wr.pop_front(), exp_wr.pop_front());
    check({nm, ".n_tags"}, obs_tag.size(), exp_tag.size());
    while (obs_tag.size() > 0 && exp_tag.size() > 0)
      check({nm, ".tag"}, obs_tag.pop_front(), exp_tag.pop_front());
    check({nm, ".n_cmp"}, obs_cmp.size(), exp_cmp.size());
    if (obs_cmp.size() > 0 && exp_cmp.size() > 0) begin
      oc = obs_cmp.pop_front();
      ec = exp_cmp.pop_front();
      check({nm, ".bus_err"}, oc[32], ec[32]);
      if (unc) check({nm, ".dc_data"}, oc[31:0], ec[31:0]);
      if (exp_lat > 0) check({nm, ".latency"}, cmp_cyc - start, exp_lat);
    end
    obs_wr.delete();  exp_wr.delete();
    obs_tag.delete(); exp_tag.delete();
    obs_cmp.delete(); exp_cmp.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    #12;
    check("reset.ctrl", {dc_cmp, a_valid, bram_wr_en, tag_wr_en, bus_err_o, d_ready}, 6'd0);
    check("reset.dc_data", dc_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // dc_req seen in cycle 0, dc_cmp high in cycle 3 (4 cycles inclusive); refill in cycle 34
    run_txn("unc_word", 32'h8000_0004, 2'd2, 1'b1, 32'hDEAD_BEEF, -1, 0, 1'b0, 3);
    run_txn("unc_byte3", 32'h8000_0003, 2'd0, 1'b1, 32'h1234_5678, -1, 0, 1'b0, 3);
    run_txn("unc_byte1", 32'h8000_0001, 2'd0, 1'b1, 32'h1234_5678, -1, 0, 1'b0, 3);
    run_txn("unc_half2", 32'h8000_0002, 2'd1, 1'b1, 32'h1234_5678, -1, 0, 1'b0, 3);
    run_txn("refill_1a84", 32'h0000_1A84, 2'd0, 1'b0, 32'd0, -1, 0, 1'b0, 34);
    run_txn("refill_w1", 32'h0000_2000, 2'd0, 1'b0, 32'h0000_0100, -1, 0, 1'b0, 34);
    run_txn("refill_w0", 32'h1234_5680, 2'd0, 1'b0, 32'h5555_0000, -1, 0, 1'b0, 34);

    // Stray response beats while idle must not be consumed
    @(posedge clk); #1;
    d_valid = 1'b1;
    d_data  = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1 d_valid = 1'b0;
    run_txn("refill_stall", 32'h0000_3F00, 2'd0, 1'b0, 32'hA000_0000, -1, 10, 1'b1, -1);
    run_txn("unc_stall", 32'h8000_0020, 2'd2, 1'b1, 32'h0BAD_F00D, -1, 10, 1'b0, -1);
    run_txn("refill_denied", 32'h0000_4080, 2'd0, 1'b0, 32'hC000_0000, 5, 0, 1'b0, 34);
    run_txn("unc_denied", 32'h8000_0010, 2'd2, 1'b1, 32'h7777_7777, 0, 0, 1'b0, 3);

    // Reset while beat 10 of a refill is on the bus
    @(posedge clk); #1;
    dc_req      = 1'b1;
    dc_addr     = 32'h0000_5A00;
    dc_op       = 2'd0;
    dc_uncached = 1'b0;
    a_ready     = 1'b1;
    repeat (2) @(posedge clk);
    #1 a_ready = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      d_valid = 1'b1;
      d_data  = 32'(k);
      if (k < 10) begin
        @(posedge clk); #1;
      end
    end
    @(negedge clk); #1;
    rst_n   = 1'b0;
    d_valid = 1'b0;
    dc_req  = 1'b0;
    #1;
    check("midrst.ctrl", {dc_cmp, a_valid, bram_wr_en, tag_wr_en, bus_err_o, d_ready}, 6'd0);
    check("midrst.dc_data", dc_data, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    victim_m = 1'b0;
    check("midrst.n_writes", obs_wr.size(), 5);
    check("midrst.n_tags", obs_tag.size(), 0);
    check("midrst.n_cmp", obs_cmp.size(), 0);
    obs_wr.delete(); obs_tag.delete(); obs_cmp.delete();

    run_txn("post_rst_half", 32'h8000_0002, 2'd1, 1'b1, 32'hCAFE_F00D, -1, 0, 1'b0, 3);
    run_txn("post_rst_refill", 32'h0000_7F80, 2'd0, 1'b0, 32'h1000_0000, -1, 0, 1'b0, 34);

    check("stray_bus_err", stray_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
